gyro_i2c_sequencer: RTL and testbench
=====================================

Name: gyro_i2c_sequencer

Overview:
Controller that owns the board's I2C master and sequences all gyroscope traffic. After reset it waits for sensor power-up and writes a fixed configuration table. It then polls the six angular-rate output registers at a fixed sample rate and publishes a signed X/Y/Z sample with a one-cycle valid strobe. It detects NACKs and hung transactions, retries a bounded number of times, then latches an error.

Parameters:
- DEV_ADDR, 7'h69, gyro 7-bit I2C address
- STARTUP_CYCLES, 1_000_000, clk cycles to wait after reset before the first transaction (10 ms at 100 MHz)
- SAMPLE_CYCLES, 1_000_000, clk cycles between sample-sequence starts (100 Hz)
- TIMEOUT_CYCLES, 200_000, maximum clk cycles from i2c_start to i2c_done
- MAX_RETRY, 3, retries per transaction before entering ERROR

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  polling allowed; when 0 the block finishes the current transaction, then holds in IDLE_WAIT
- clear_error  in  1  pulse; leaves ERROR and restarts at CFG
- i2c_start  out  1  one-cycle transaction request to the master
- i2c_dev_addr  out  7  always DEV_ADDR
- i2c_reg_addr  out  8  register address for the current transaction
- i2c_wdata  out  8  write data (config phase only)
- i2c_read_req  out  1  1 = read one byte, 0 = write
- i2c_done  in  1  one-cycle transaction complete
- i2c_ack  in  1  slave acked; sampled with i2c_done
- i2c_rdata  in  8  read byte; valid with i2c_done
- gyro_x, gyro_y, gyro_z  out  16 each  signed rate sample, {H,L}
- sample_valid  out  1  one-cycle strobe; new gyro_* valid
- busy  out  1  transaction outstanding
- error  out  1  sticky; set on retry exhaustion
- nack_count  out  8  saturating count of NACK and timeout events

Behaviour:
- Reset: the following outputs are 0: i2c_start, i2c_reg_addr, i2c_wdata, i2c_read_req, gyro_*, sample_valid, busy, error, nack_count. i2c_dev_addr = DEV_ADDR. State is STARTUP. All counters are 0.
- Configuration table (package constants), in order: (0x20, 0x0F) enables all axes in normal mode; (0x23, 0x30) selects 2000 dps full scale.
- Read table: 0x28..0x2D = XL, XH, YL, YH, ZL, ZH. Registers are read one byte per transaction, idx 0..5.
- STARTUP: count to STARTUP_CYCLES-1, then go to CFG_ISSUE with idx = 0.
- CFG_ISSUE: drive reg, wdata and read_req = 0, pulse i2c_start for 1 cycle, set busy, go to CFG_WAIT.
- CFG_WAIT:
  - i2c_done with ack = 1: go to the next idx. After the last entry, go to IDLE_WAIT.
  - NACK or timeout: go to RETRY.
- IDLE_WAIT:
  - The sample timer runs freely from CFG completion and wraps at SAMPLE_CYCLES-1.
  - On wrap with enable = 1, go to RD_ISSUE with idx = 0.
  - A wrap while enable = 0 is dropped, not queued.
- RD_ISSUE and RD_WAIT follow the same pattern as CFG_ISSUE and CFG_WAIT with read_req = 1.
  - Each acked byte is stored in a 6-byte staging buffer; gyro_* are not touched.
  - After idx 5, go to PUBLISH.
- PUBLISH:
  - Load gyro_x = {b1, b0}, gyro_y = {b3, b2}, gyro_z = {b5, b4} simultaneously.
  - Pulse sample_valid for 1 cycle, then return to IDLE_WAIT.
  - Latency from i2c_done of byte 5 to sample_valid is 1 cycle; gyro_* change on the same edge as sample_valid rises.
- Timeout counter: cleared on i2c_start and incremented while in a WAIT state. Reaching TIMEOUT_CYCLES counts as a failure. A late i2c_done arriving afterwards is ignored, because it is only honoured in WAIT states.
- RETRY:
  - nack_count increments, saturating at 255. retry_cnt increments.
  - If retry_cnt < MAX_RETRY, reissue the same idx. A failure in the read phase restarts the read sequence at idx 0, so a sample never mixes bytes from different reads.
  - Otherwise go to ERROR.
  - retry_cnt clears on any acked transaction.
- ERROR: set error = 1 and busy = 0, issue nothing. clear_error clears error and retry_cnt and goes to CFG_ISSUE with idx = 0. clear_error is ignored in all other states.
- busy is 1 from the i2c_start cycle through the cycle that i2c_done is accepted, or until timeout.
- i2c_start is never asserted while busy is 1; at most one transaction is outstanding.
- Simultaneous timeout and i2c_done on the same cycle: i2c_done wins.
- If rst_n is asserted mid-transaction, all state returns to reset values immediately. The I2C master is reset by the same rst_n.

Decomposition:
- Package gyro_pkg holds:
  - the state_t enum
  - GYRO_REG_CTRL1 = 0x20, GYRO_REG_CTRL4 = 0x23, GYRO_REG_OUT_X_L = 0x28
  - the cfg table as an array of {reg, data}, with CFG_LEN = 2
  - RD_LEN = 6
- One sub-module, seq_timer: a loadable down-counter with a terminal-count pulse. It is instantiated three times: startup delay, sample period and transaction timeout.

Test Plan:
Bench uses STARTUP_CYCLES = 20, SAMPLE_CYCLES = 500, TIMEOUT_CYCLES = 50, MAX_RETRY = 2, plus a behavioural slave model.
- Reset release: first i2c_start appears at cycle 20 with reg 0x20, wdata 0x0F, read_req 0; the second carries 0x23/0x30.
- Slave returns 0x34, 0x12, 0xCD, 0xAB, 0x00, 0x80 -> one sample_valid with gyro_x = 0x1234, gyro_y = 0xABCD, gyro_z = 0x8000; a second sample starts 500 cycles after the first.
- Slave NACKs 0x2A once -> nack_count = 1, the read restarts at 0x28, and sample_valid shows fresh data.
- Slave never asserts done -> busy drops 50 cycles after start. After 3 failures error = 1 and nack_count = 3; clear_error causes config to be rewritten starting at 0x20.
- enable dropped mid-read -> the current sequence completes and publishes once, then no i2c_start occurs until enable returns.
- rst_n asserted during RD_WAIT -> all outputs return to reset values on the same cycle, and the startup delay restarts.

Source files
------------

// File: rtl/gyro_pkg.sv
// gyro_pkg: shared states, register map and configuration table for the gyro sequencer
package gyro_pkg;
  typedef enum logic [3:0] {
    STARTUP, CFG_ISSUE, CFG_WAIT, IDLE_WAIT, RD_ISSUE, RD_WAIT, PUBLISH, RETRY, ERROR
  } state_t;
  typedef struct packed {
    logic [7:0] reg_addr;
    logic [7:0] data;
  } cfg_entry_t;
  localparam logic [7:0] GYRO_REG_CTRL1 = 8'h20;
  localparam logic [7:0] GYRO_REG_CTRL4 = 8'h23;
  localparam logic [7:0] GYRO_REG_OUT_X_L = 8'h28;
  localparam int CFG_LEN = 2;
  localparam int RD_LEN = 6;
  localparam cfg_entry_t CFG_TABLE [CFG_LEN] = '{'{GYRO_REG_CTRL1, 8'h0F}, '{GYRO_REG_CTRL4, 8'h30}};
endpackage

// File: rtl/gyro_i2c_sequencer_seq_timer.sv
// seq_timer: loadable down-counter with an auto-reloading terminal-count pulse
module seq_timer #(
  parameter int W = 32,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         tc
);
  logic [W-1:0] cnt;
  assign tc = en && !load && cnt == '0;
  // reload on request or on terminal count, otherwise count down while enabled
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= RST_VAL;
    else if (load || tc) cnt <= load_val;
    else if (en) cnt <= cnt - 1'b1;
endmodule

// File: rtl/gyro_i2c_sequencer.sv
// gyro_i2c_sequencer: configures the gyro over I2C, then polls X/Y/Z rate samples with retry and error handling
module gyro_i2c_sequencer
  import gyro_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h69,
  parameter int STARTUP_CYCLES = 1_000_000,
  parameter int SAMPLE_CYCLES = 1_000_000,
  parameter int TIMEOUT_CYCLES = 200_000,
  parameter int MAX_RETRY = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               clear_error,
  output logic               i2c_start,
  output logic [6:0]         i2c_dev_addr,
  output logic [7:0]         i2c_reg_addr,
  output logic [7:0]         i2c_wdata,
  output logic               i2c_read_req,
  input  logic               i2c_done,
  input  logic               i2c_ack,
  input  logic [7:0]         i2c_rdata,
  output logic signed [15:0] gyro_x,
  output logic signed [15:0] gyro_y,
  output logic signed [15:0] gyro_z,
  output logic               sample_valid,
  output logic               busy,
  output logic               error,
  output logic [7:0]         nack_count
);
  state_t state, state_nx;
  logic [2:0] idx;
  logic [7:0] retry_cnt;
  logic [7:0] stage [RD_LEN];
  logic in_rd, sample_run, startup_tc, sample_tc, to_tc;
  logic is_wait, cfg_ph, ok, fail, cfg_last, rd_last, cfg_done;
  assign is_wait = state == CFG_WAIT || state == RD_WAIT;
  assign cfg_ph = state == CFG_ISSUE || state == CFG_WAIT;
  assign ok = is_wait && i2c_done && i2c_ack;
  assign fail = is_wait && (i2c_done ? !i2c_ack : to_tc);
  assign cfg_last = idx == 3'(CFG_LEN - 1);
  assign rd_last = idx == 3'(RD_LEN - 1);
  assign cfg_done = ok && state == CFG_WAIT && cfg_last;
  assign i2c_dev_addr = DEV_ADDR;
  assign i2c_start = state == CFG_ISSUE || state == RD_ISSUE;
  assign i2c_read_req = state == RD_ISSUE || state == RD_WAIT;
  assign busy = i2c_start || is_wait;
  assign i2c_reg_addr = cfg_ph ? CFG_TABLE[idx[0]].reg_addr : i2c_read_req ? GYRO_REG_OUT_X_L + {5'd0, idx} : '0;
  assign i2c_wdata = cfg_ph ? CFG_TABLE[idx[0]].data : '0;
  assign sample_valid = state == PUBLISH;
  assign error = state == ERROR;
  seq_timer #(.W(32), .RST_VAL(32'(STARTUP_CYCLES - 1))) u_startup (
    .clk(clk), .rst_n(rst_n), .load(1'b0), .en(state == STARTUP),
    .load_val(32'(STARTUP_CYCLES - 1)), .tc(startup_tc)
  );
  seq_timer #(.W(32)) u_sample (
    .clk(clk), .rst_n(rst_n), .load(cfg_done), .en(sample_run),
    .load_val(32'(SAMPLE_CYCLES - 1)), .tc(sample_tc)
  );
  seq_timer #(.W(32)) u_timeout (
    .clk(clk), .rst_n(rst_n), .load(i2c_start), .en(is_wait),
    .load_val(32'(TIMEOUT_CYCLES - 2)), .tc(to_tc)
  );
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= STARTUP;
    else state <= state_nx;
  // next-state: done beats timeout, read-phase retries restart from the first byte
  always_comb begin
    state_nx = state;
    case (state)
      STARTUP:   state_nx = startup_tc ? CFG_ISSUE : STARTUP;
      CFG_ISSUE: state_nx = CFG_WAIT;
      CFG_WAIT:  state_nx = fail ? RETRY : !ok ? CFG_WAIT : cfg_last ? IDLE_WAIT : CFG_ISSUE;
      IDLE_WAIT: state_nx = sample_tc && enable ? RD_ISSUE : IDLE_WAIT;
      RD_ISSUE:  state_nx = RD_WAIT;
      RD_WAIT:   state_nx = fail ? RETRY : !ok ? RD_WAIT : rd_last ? PUBLISH : RD_ISSUE;
      PUBLISH:   state_nx = IDLE_WAIT;
      RETRY:     state_nx = retry_cnt > 8'(MAX_RETRY) ? ERROR : in_rd ? RD_ISSUE : CFG_ISSUE;
      ERROR:     state_nx = clear_error ? CFG_ISSUE : ERROR;
      default:   state_nx = STARTUP;
    endcase
  end
  // datapath: index, retry bookkeeping, staging buffer and sample publish
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx <= '0;
      in_rd <= 1'b0;
      sample_run <= 1'b0;
      retry_cnt <= '0;
      nack_count <= '0;
      stage <= '{default: '0};
      gyro_x <= '0;
      gyro_y <= '0;
      gyro_z <= '0;
    end else begin
      if (ok) idx <= (state == CFG_WAIT ? cfg_last : rd_last) ? '0 : idx + 3'd1;
      else if ((state == RETRY && in_rd) || state == ERROR) idx <= '0;
      if (state == RD_ISSUE) in_rd <= 1'b1;
      else if (state == CFG_ISSUE) in_rd <= 1'b0;
      if (cfg_done) sample_run <= 1'b1;
      if (ok || (state == ERROR && clear_error)) retry_cnt <= '0;
      else if (fail) retry_cnt <= retry_cnt + 8'd1;
      if (fail && nack_count != 8'hFF) nack_count <= nack_count + 8'd1;
      if (ok && state == RD_WAIT) stage[idx] <= i2c_rdata;
      if (ok && state == RD_WAIT && rd_last) begin
        gyro_x <= {stage[1], stage[0]};
        gyro_y <= {stage[3], stage[2]};
        gyro_z <= {i2c_rdata, stage[4]};
      end
    end
endmodule

// File: tb/tb_gyro_i2c_sequencer.sv
// tb_gyro_i2c_sequencer: directed checks of config, sampling, NACK/timeout retry, enable gating and reset
module tb_gyro_i2c_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b1, clear_error = 1'b0;
  logic i2c_start, i2c_read_req, i2c_done, i2c_ack;
  logic [6:0] i2c_dev_addr;
  logic [7:0] i2c_reg_addr, i2c_wdata, i2c_rdata, nack_count;
  logic signed [15:0] gyro_x, gyro_y, gyro_z;
  logic sample_valid, busy, error;

  gyro_i2c_sequencer #(
    .DEV_ADDR(7'h69), .STARTUP_CYCLES(20), .SAMPLE_CYCLES(500), .TIMEOUT_CYCLES(50), .MAX_RETRY(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear_error(clear_error),
    .i2c_start(i2c_start), .i2c_dev_addr(i2c_dev_addr), .i2c_reg_addr(i2c_reg_addr),
    .i2c_wdata(i2c_wdata), .i2c_read_req(i2c_read_req), .i2c_done(i2c_done), .i2c_ack(i2c_ack),
    .i2c_rdata(i2c_rdata), .gyro_x(gyro_x), .gyro_y(gyro_y), .gyro_z(gyro_z),
    .sample_valid(sample_valid), .busy(busy), .error(error), .nack_count(nack_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    logic [7:0] reg_a;
    logic [7:0] wd;
    logic rd;
  } txn_t;
  typedef struct {
    logic [47:0] raw;
    logic [15:0] x, y, z;
  } vec_t;

  txn_t log_q[$];
  int rd_q[$];
  int cyc, compared = 0, mismatched = 0;
  int n_samples = 0, dbl = 0, busy_fall = -1;
  logic [15:0] sx, sy, sz;
  logic sv_prev = 1'b0, busy_prev = 1'b0;
  logic [7:0] mem [6];
  logic hang = 1'b0, nack_hit = 1'b0;
  logic [7:0] nack_reg = 8'h00, after_nack_reg = 8'h00;
  int nack_left = 0;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_mem(input logic [47:0] raw);
    for (int i = 0; i < 6; i++) mem[i] = raw[8*i +: 8];
  endtask

  task automatic wait_samples(input int n, input int budget, input string name);
    for (int i = 0; i < budget && n_samples < n; i++) @(negedge clk);
    chk(name, 32'(n_samples >= n), 32'd1);
  endtask

  task automatic wait_log(input int n, input int budget, input string name);
    for (int i = 0; i < budget && log_q.size() < n; i++) @(negedge clk);
    chk(name, 32'(log_q.size() >= n), 32'd1);
  endtask

  // behavioural I2C slave: answers each start two cycles later unless hung
  initial begin
    txn_t t;
    i2c_done = 1'b0;
    i2c_ack = 1'b0;
    i2c_rdata = 8'h00;
    forever begin
      @(negedge clk);
      i2c_done = 1'b0;
      i2c_ack = 1'b0;
      if (rst_n && i2c_start) begin
        t.cyc = cyc;
        t.reg_a = i2c_reg_addr;
        t.wd = i2c_wdata;
        t.rd = i2c_read_req;
        log_q.push_back(t);
        if (t.reg_a == 8'h28 && t.rd) rd_q.push_back(cyc);
        if (nack_hit) begin
          after_nack_reg = t.reg_a;
          nack_hit = 1'b0;
        end
        if (!hang) begin
          @(negedge clk);
          @(negedge clk);
          i2c_ack = !(t.reg_a == nack_reg && nack_left > 0);
          if (!i2c_ack) begin
            nack_left--;
            nack_hit = 1'b1;
          end
          i2c_rdata = (t.rd && t.reg_a >= 8'h28 && t.reg_a <= 8'h2D) ? mem[int'(t.reg_a) - 40] : 8'h00;
          i2c_done = 1'b1;
        end
      end
    end
  end

  // output monitor: sample strobes and busy falling edges
  initial forever begin
    @(negedge clk);
    if (sample_valid) begin
      n_samples++;
      sx = gyro_x;
      sy = gyro_y;
      sz = gyro_z;
      if (sv_prev) dbl++;
    end
    sv_prev = sample_valid;
    if (busy_prev && !busy) busy_fall = cyc;
    busy_prev = busy;
  end

  initial begin
    vec_t vecs[3];
    int base, s_cyc, ns;
    vecs[0] = '{48'h8000_ABCD_1234, 16'h1234, 16'hABCD, 16'h8000};
    vecs[1] = '{48'hFFFF_0001_7FFF, 16'h7FFF, 16'h0001, 16'hFFFF};
    vecs[2] = '{48'hA55A_0080_0000, 16'h0000, 16'h0080, 16'hA55A};
    load_mem(vecs[0].raw);
    #1;
    chk("rst_start", 32'(i2c_start), 0);
    chk("rst_dev_addr", 32'(i2c_dev_addr), 32'h69);
    chk("rst_reg", 32'(i2c_reg_addr), 0);
    chk("rst_wdata", 32'(i2c_wdata), 0);
    chk("rst_read_req", 32'(i2c_read_req), 0);
    chk("rst_gyro", {16'(gyro_x | gyro_y), 16'(gyro_z)}, 0);
    chk("rst_flags", {sample_valid, busy, error}, 0);
    chk("rst_nack", 32'(nack_count), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_log(2, 100, "cfg_starts_seen");
    if (log_q.size() >= 2) begin
      chk("cfg0_cycle", log_q[0].cyc, 20);
      chk("cfg0_txn", {log_q[0].reg_a, log_q[0].wd, 7'd0, log_q[0].rd}, {8'h20, 8'h0F, 8'd0});
      chk("cfg1_txn", {log_q[1].reg_a, log_q[1].wd, 7'd0, log_q[1].rd}, {8'h23, 8'h30, 8'd0});
    end
    for (int v = 0; v < 3; v++) begin
      wait_samples(v + 1, 1200, "sample_arrived");
      chk("gyro_x", 32'(sx), 32'(vecs[v].x));
      chk("gyro_y", 32'(sy), 32'(vecs[v].y));
      chk("gyro_z", 32'(sz), 32'(vecs[v].z));
      if (v < 2) load_mem(vecs[v + 1].raw);
    end
    for (int i = 0; i < 6; i++)
      chk("read_order", {24'd0, log_q[2 + i].reg_a}, {24'd0, 8'h28 + 8'(i)} | {31'd0, !log_q[2 + i].rd});
    chk("sample_period", rd_q[1] - rd_q[0], 500);
    chk("no_nack_yet", 32'(nack_count), 0);
    // hung slave: timeout, two retries, then sticky error
    hang = 1'b1;
    base = log_q.size();
    wait_log(base + 1, 700, "hung_start_seen");
    s_cyc = log_q[base].cyc;
    for (int i = 0; i < 100 && busy_fall <= s_cyc; i++) @(negedge clk);
    chk("timeout_busy_len", busy_fall - s_cyc, 50);
    for (int i = 0; i < 400 && !error; i++) @(negedge clk);
    chk("error_set", 32'(error), 1);
    chk("error_nack", 32'(nack_count), 3);
    chk("error_attempts", log_q.size() - base, 3);
    chk("error_busy", 32'(busy), 0);
    base = log_q.size();
    repeat (100) @(negedge clk);
    chk("error_quiet", log_q.size() - base, 0);
    chk("error_sticky", 32'(error), 1);
    hang = 1'b0;
    clear_error = 1'b1;
    @(negedge clk);
    clear_error = 1'b0;
    wait_log(base + 2, 100, "recfg_seen");
    chk("error_cleared", 32'(error), 0);
    if (log_q.size() >= base + 2) begin
      chk("recfg0", {log_q[base].reg_a, log_q[base].wd, 7'd0, log_q[base].rd}, {8'h20, 8'h0F, 8'd0});
      chk("recfg1", {log_q[base + 1].reg_a, log_q[base + 1].wd, 7'd0, log_q[base + 1].rd}, {8'h23, 8'h30, 8'd0});
    end
    // single NACK on YL: read restarts at XL and publishes fresh data
    load_mem(48'h6655_4433_2211);
    nack_reg = 8'h2A;
    nack_left = 1;
    wait_samples(n_samples + 1, 1200, "nack_sample_arrived");
    chk("nack_count", 32'(nack_count), 4);
    chk("nack_restart_reg", 32'(after_nack_reg), 32'h28);
    chk("nack_gyro", {sx, sy}, 32'h2211_4433);
    chk("nack_gyro_z", 32'(sz), 32'h6655);
    // enable dropped mid-read: finish and publish once, then stay quiet
    base = rd_q.size();
    for (int i = 0; i < 700 && rd_q.size() == base; i++) @(negedge clk);
    enable = 1'b0;
    ns = n_samples;
    wait_samples(ns + 1, 50, "disable_publish");
    base = log_q.size();
    ns = n_samples;
    repeat (1200) @(negedge clk);
    chk("disable_no_start", log_q.size() - base, 0);
    chk("disable_no_sample", n_samples - ns, 0);
    enable = 1'b1;
    wait_log(base + 1, 600, "reenable_start");
    if (log_q.size() > base) chk("reenable_reg", 32'(log_q[base].reg_a), 32'h28);
    // asynchronous reset during RD_WAIT
    base = rd_q.size();
    for (int i = 0; i < 700 && rd_q.size() == base; i++) @(negedge clk);
    @(negedge clk);
    chk("pre_reset_busy", {i2c_read_req, busy}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy_start", {i2c_start, busy, i2c_read_req}, 0);
    chk("arst_reg", 32'(i2c_reg_addr), 0);
    chk("arst_gyro", {16'(gyro_x | gyro_y), 16'(gyro_z)}, 0);
    chk("arst_nack_err", {nack_count, 7'd0, error, 7'd0, sample_valid}, 0);
    repeat (2) @(negedge clk);
    base = log_q.size();
    rst_n = 1'b1;
    wait_log(base + 1, 100, "restart_seen");
    if (log_q.size() > base) begin
      chk("restart_cycle", log_q[base].cyc, 20);
      chk("restart_reg", 32'(log_q[base].reg_a), 32'h20);
    end
    chk("sv_one_cycle", dbl, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
